// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle MIPS control FSM. Sequences one instruction over
//               3-5 cycles (fetch/decode/execute/memory/writeback), drives
//               the datapath mux selects and enables, stalls on mem_ready,
//               and provides run/halt, a sticky illegal-opcode flag and a
//               retired-instruction counter.
//               Optional macro MULTICYCLE_BNE_EN adds a BRANCH_NE state and
//               the branch_ne output for opcode 000101.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W        = 6,
    parameter int ALUOP_W         = 2,
    parameter int CNT_W           = 32,
    parameter int STOP_ON_ILLEGAL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                halted,
    output logic                illegal,
`ifdef MULTICYCLE_BNE_EN
    output logic                branch_ne,
`endif
    output logic [3:0]          state_dbg,
    output logic [CNT_W-1:0]    instr_count
);

    // State encodings (visible on state_dbg)
    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_FETCH     = 4'd1;
    localparam logic [3:0] c_S_DECODE    = 4'd2;
    localparam logic [3:0] c_S_MEMADR    = 4'd3;
    localparam logic [3:0] c_S_MEMRD     = 4'd4;
    localparam logic [3:0] c_S_MEMWB     = 4'd5;
    localparam logic [3:0] c_S_MEMWR     = 4'd6;
    localparam logic [3:0] c_S_RTYPE_EX  = 4'd7;
    localparam logic [3:0] c_S_RTYPE_WB  = 4'd8;
    localparam logic [3:0] c_S_ADDI_EX   = 4'd9;
    localparam logic [3:0] c_S_ADDI_WB   = 4'd10;
    localparam logic [3:0] c_S_BRANCH    = 4'd11;
    localparam logic [3:0] c_S_JUMP      = 4'd12;
    localparam logic [3:0] c_S_HALT      = 4'd13;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [3:0] c_S_BRANCH_NE = 4'd14;
`endif

    // Opcode values recognised in DECODE
    localparam logic [OPCODE_W-1:0] c_OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] c_OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] c_OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] c_OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] c_OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] c_OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] c_OP_HALT  = OPCODE_W'(6'b111111);
`ifdef MULTICYCLE_BNE_EN
    localparam logic [OPCODE_W-1:0] c_OP_BNE   = OPCODE_W'(6'b000101);
`endif

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [3:0]       w_dec_next;
    logic             w_dec_illegal;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode decode: target state after DECODE and illegal detection
    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_next    = c_S_FETCH;
        case (opcode)
            c_OP_RTYPE:       w_dec_next = c_S_RTYPE_EX;
            c_OP_ADDI:        w_dec_next = c_S_ADDI_EX;
            c_OP_LW, c_OP_SW: w_dec_next = c_S_MEMADR;
            c_OP_BEQ:         w_dec_next = c_S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
            c_OP_BNE:         w_dec_next = c_S_BRANCH_NE;
`endif
            c_OP_J:           w_dec_next = c_S_JUMP;
            c_OP_HALT:        w_dec_next = c_S_HALT;
            default: begin
                w_dec_illegal = 1'b1;
                w_dec_next    = (STOP_ON_ILLEGAL != 0) ? c_S_HALT : c_S_FETCH;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:     w_next_state = run ? c_S_FETCH : c_S_IDLE;
            c_S_FETCH:    w_next_state = mem_ready ? c_S_DECODE : c_S_FETCH;
            c_S_DECODE:   w_next_state = w_dec_next;
            // IR holds the opcode, so only lw vs. anything else matters here
            c_S_MEMADR:   w_next_state = (opcode == c_OP_LW) ? c_S_MEMRD : c_S_MEMWR;
            c_S_MEMRD:    w_next_state = mem_ready ? c_S_MEMWB : c_S_MEMRD;
            c_S_MEMWB:    w_next_state = c_S_FETCH;
            c_S_MEMWR:    w_next_state = mem_ready ? c_S_FETCH : c_S_MEMWR;
            c_S_RTYPE_EX: w_next_state = c_S_RTYPE_WB;
            c_S_RTYPE_WB: w_next_state = c_S_FETCH;
            c_S_ADDI_EX:  w_next_state = c_S_ADDI_WB;
            c_S_ADDI_WB:  w_next_state = c_S_FETCH;
            c_S_BRANCH:   w_next_state = c_S_FETCH;
`ifdef MULTICYCLE_BNE_EN
            c_S_BRANCH_NE: w_next_state = c_S_FETCH;
`endif
            c_S_JUMP:     w_next_state = c_S_FETCH;
            c_S_HALT:     w_next_state = c_S_HALT;
            default:      w_next_state = c_S_IDLE;
        endcase
    end

    // Moore output decode; FETCH write enables wait for the memory
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = '0;
        pc_source     = 2'b00;
        halted        = 1'b0;
`ifdef MULTICYCLE_BNE_EN
        branch_ne     = 1'b0;
`endif
        case (r_state)
            c_S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            c_S_DECODE: begin
                alu_src_b = 2'b11;
            end
            c_S_MEMADR, c_S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            c_S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            c_S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            c_S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            c_S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(2'b10);
            end
            c_S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            c_S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            c_S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(2'b01);
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
`ifdef MULTICYCLE_BNE_EN
            c_S_BRANCH_NE: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(2'b01);
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = 1'b1;
            end
`endif
            c_S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            c_S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    // Sticky illegal flag and retired-fetch counter (wraps naturally)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            if (r_state == c_S_DECODE && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
            if (r_state == c_S_FETCH && mem_ready) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign illegal     = r_illegal;
    assign instr_count = r_count;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle control decoder.
- Sequences one MIPS instruction over 3–5 cycles: fetch, decode, execute, memory, writeback.
- Drives the multi-cycle datapath muxes and enables, and stalls on a memory ready handshake.
- Adds a run/halt handshake, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, alu_op width. Must be ≥2; upper bits are driven 0.
- CNT_W, 32, instr_count width.
- STOP_ON_ILLEGAL, 0:
  - 1: an illegal opcode goes to HALT.
  - 0: the illegal instruction is skipped and the FSM returns to FETCH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  start request, sampled in IDLE.
- opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data select: 1 = MDR.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- state_dbg  out  4  current state encoding.
- instr_count  out  CNT_W  retired fetch count.

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, ADDI_EX=9, ADDI_WB=10, BRANCH=11, JUMP=12, HALT=13.
- Reset (asynchronous):
  - state = IDLE, illegal = 0, instr_count = 0.
  - All control outputs 0; state_dbg = 0.
- Outputs are Moore, decoded from state. Exception: ir_write and pc_write in FETCH are qualified by mem_ready.
  - Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run = 1; otherwise stay.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - mem_ready = 1: go to DECODE and increment instr_count (wraps at 2^CNT_W).
  - mem_ready = 0: stay in FETCH with requests held.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
  - 000000 → RTYPE_EX
  - 001000 → ADDI_EX
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 111111 → HALT
  - anything else: illegal ← 1, then HALT if STOP_ON_ILLEGAL, else FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEMRD if lw, MEMWR if sw. The opcode is held stable by the IR.
- MEMRD: mem_read = 1, i_or_d = 1. Go to MEMWB on mem_ready; otherwise stay.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Go to FETCH on mem_ready; otherwise stay.
- RTYPE_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to RTYPE_WB.
- RTYPE_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Go to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Go to FETCH.
- HALT: halted = 1, all others 0. Absorbing; only reset exits. run is ignored.
- Cycle counts with mem_ready tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Boundary conditions:
  - mem_ready asserted outside FETCH, MEMRD and MEMWR is ignored.
  - Reset mid-instruction returns to IDLE immediately (asynchronous); illegal and instr_count are cleared.
  - A second illegal opcode leaves illegal at 1.
  - run is only sampled in IDLE.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined:
  - Opcode 000101 in DECODE goes to BRANCH_NE=14. BRANCH_NE drives the same outputs as BRANCH plus branch_ne = 1, which the datapath uses to invert zero. Then FETCH.
  - Extra output port: branch_ne  out  1.
- Undefined:
  - No branch_ne port.
  - Opcode 000101 is treated as illegal.

Test Plan:
- Reset with run = 0 for 5 cycles → state_dbg = 0, all outputs 0, instr_count = 0.
- run = 1, mem_ready = 1, opcode = 100011 → states 1, 2, 3, 4, 5, then 1.
  - MEMWB has reg_write = 1 and mem_to_reg = 1.
  - instr_count = 1.
- opcode = 101011, mem_ready low for 3 cycles in MEMWR → mem_write held 4 cycles, FETCH only after mem_ready, reg_write never 1.
- Sequence R-type, addi, beq, j → cycle counts 4, 4, 3, 3, instr_count = 4.
  - BRANCH: pc_write_cond = 1, alu_op = 01, pc_source = 01.
  - JUMP: pc_source = 10.
- opcode = 010001:
  - STOP_ON_ILLEGAL = 0 → illegal = 1, back to FETCH.
  - STOP_ON_ILLEGAL = 1 → halted = 1 and stays with run toggling.
- Assert reset during MEMRD → IDLE on the same edge, illegal = 0, instr_count = 0; opcode 111111 then gives halted = 1 after 2 cycles in FETCH/DECODE.
